// File: rtl/tele_tx_frame.sv
// Serial telemetry frame transmitter: accepts address/data words over valid/ready and
// sends preamble, address, data and parity on o_tx, followed by a forced-low gap.
module tele_tx_frame #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 4,
    parameter int PRE_W = 4,
    parameter logic [PRE_W-1:0] PREAMBLE = 4'b1010,
    parameter int BIT_CLKS = 1,
    parameter int GAP_CLKS = 20,
    parameter int STARTUP_CLKS = 2000,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_tx_flag,
    output logic [ADDR_W-1:0] o_tx_addr,
    output logic [DATA_W-1:0] o_tx_data
);

    localparam int FRAME_W = PRE_W + ADDR_W + DATA_W + 1;
    localparam int BIT_W = $clog2(BIT_CLKS + 1);
    localparam int IDX_W = $clog2(FRAME_W + 1);
    localparam int GAP_W = $clog2(GAP_CLKS + 1);
    localparam int ST_W = $clog2(STARTUP_CLKS + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_CLKS - 1);
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(FRAME_W);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STARTUP_CLKS - 1);
    // The completion cycle is the first cycle of the low gap, so S_GAP lasts GAP_CLKS-1 cycles.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 1) ? GAP_CLKS - 2 : 0);

    localparam logic [1:0] S_STARTUP = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_RUN = 2'd2;
    localparam logic [1:0] S_GAP = 2'd3;

    logic [1:0]         state;
    logic [ST_W-1:0]    st_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [IDX_W-1:0]   bit_idx;
    logic [GAP_W-1:0]   gap_cnt;
    logic [FRAME_W-1:0] shreg;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_data;
    logic               parity;

    assign o_ready = (state == S_IDLE);
    assign o_busy = (state == S_RUN) || (state == S_GAP);
    assign parity = (^{PREAMBLE, i_addr, i_data}) ^ PARITY_ODD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_STARTUP;
            st_cnt    <= '0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            gap_cnt   <= '0;
            shreg     <= '0;
            lat_addr  <= '0;
            lat_data  <= '0;
            o_tx      <= 1'b0;
            o_tx_flag <= 1'b0;
            o_tx_addr <= '0;
            o_tx_data <= '0;
        end else begin
            o_tx_flag <= 1'b0;
            o_tx_addr <= '0;
            o_tx_data <= '0;
            case (state)
                S_STARTUP: begin
                    o_tx <= 1'b0;
                    if (st_cnt == ST_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        st_cnt <= st_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    o_tx <= 1'b0;
                    if (i_valid) begin
                        shreg    <= {PREAMBLE, i_addr, i_data, parity};
                        lat_addr <= i_addr;
                        lat_data <= i_data;
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bit_cnt == '0 && bit_idx == IDX_END) begin
                        o_tx      <= 1'b0;
                        o_tx_flag <= 1'b1;
                        o_tx_addr <= lat_addr;
                        o_tx_data <= lat_data;
                        gap_cnt   <= '0;
                        state     <= (GAP_CLKS > 1) ? S_GAP : S_IDLE;
                    end else begin
                        // A new bit is presented at the start of each bit period.
                        if (bit_cnt == '0) begin
                            o_tx  <= shreg[FRAME_W-1];
                            shreg <= {shreg[FRAME_W-2:0], 1'b0};
                        end
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            bit_idx <= bit_idx + 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    o_tx <= 1'b0;
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    o_tx   <= 1'b0;
                    st_cnt <= '0;
                    state  <= S_STARTUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tele_tx_frame.sv
// Self-checking bench for tele_tx_frame: default, odd-parity and wide/slow instances
// checked cycle by cycle against a frame model built from the field layout.
module tb_tele_tx_frame;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       v0, rdy0, tx0, busy0, flag0;
    logic [6:0] a0, fa0;
    logic [3:0] d0, fd0;

    logic       v1, rdy1, tx1, busy1, flag1;
    logic [6:0] a1, fa1;
    logic [3:0] d1, fd1;

    logic       v2, rdy2, tx2, busy2, flag2;
    logic [7:0] a2, fa2, d2, fd2;

    int n_cmp = 0;
    int n_err = 0;

    tele_tx_frame dut (
        .clk(clk), .rst(rst), .i_valid(v0), .o_ready(rdy0), .i_addr(a0), .i_data(d0),
        .o_tx(tx0), .o_busy(busy0), .o_tx_flag(flag0), .o_tx_addr(fa0), .o_tx_data(fd0)
    );

    tele_tx_frame #(.PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .i_valid(v1), .o_ready(rdy1), .i_addr(a1), .i_data(d1),
        .o_tx(tx1), .o_busy(busy1), .o_tx_flag(flag1), .o_tx_addr(fa1), .o_tx_data(fd1)
    );

    tele_tx_frame #(.ADDR_W(8), .DATA_W(8), .BIT_CLKS(3)) dut_wide (
        .clk(clk), .rst(rst), .i_valid(v2), .o_ready(rdy2), .i_addr(a2), .i_data(d2),
        .o_tx(tx2), .o_busy(busy2), .o_tx_flag(flag2), .o_tx_addr(fa2), .o_tx_data(fd2)
    );

    // Bit j of the frame {1010, addr, data, parity}, parity making the total XOR equal odd.
    function automatic logic exp_bit(int aw, int dw, int odd, logic [63:0] addr,
                                     logic [63:0] data, int j);
        logic [63:0] frame;
        int fw;
        fw = 4 + aw + dw + 1;
        frame = (64'hA << (aw + dw + 1)) | (addr << (dw + 1)) | (data << 1);
        frame = frame | 64'((($countones(frame) % 2) + odd) % 2);
        return frame[fw-1-j];
    endfunction

    task automatic test_reset();
        int n;
        v0 = 1'b1; a0 = 7'h5A; d0 = 4'h3;
        v1 = 1'b0; a1 = '0; d1 = '0;
        v2 = 1'b0; a2 = '0; d2 = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({tx0, flag0, rdy0, busy0, fa0, fd0} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_outputs actual=%b required=0", {tx0, flag0, rdy0, busy0, fa0, fd0});
        end
        rst = 1'b0;
        n = 2101;
        for (int i = 1; i <= 2100; i++) begin
            @(negedge clk);
            if (rdy0 === 1'b1) begin
                n = i;
                break;
            end
        end
        n_cmp++;
        if (n != 2000) begin
            n_err++;
            $display("FAIL startup_len actual=%0d required=2000", n);
        end
        n_cmp++;
        if ({rdy1, rdy2} !== 2'b11) begin
            n_err++;
            $display("FAIL startup_other actual=%b required=11", {rdy1, rdy2});
        end
    endtask

    // Entered with o_ready high; i_valid may already be held from reset (first-cycle acceptance).
    task automatic test_frame_default();
        logic [6:0] a;
        logic [3:0] d;
        logic exp_tx;
        for (int f = 0; f < 4; f++) begin
            a = (f == 0) ? 7'h5A : 7'($urandom);
            d = (f == 0) ? 4'h3 : 4'($urandom);
            n_cmp++;
            if (rdy0 !== 1'b1) begin
                n_err++;
                $display("FAIL frame_ready_in f=%0d actual=%b required=1", f, rdy0);
            end
            v0 = 1'b1; a0 = a; d0 = d;
            for (int p = 0; p <= 36; p++) begin
                @(negedge clk);
                exp_tx = (p >= 1 && p <= 16) ? exp_bit(7, 4, 0, 64'(a), 64'(d), p - 1) : 1'b0;
                n_cmp++;
                if (tx0 !== exp_tx) begin
                    n_err++;
                    $display("FAIL frame_tx f=%0d p=%0d actual=%b required=%b", f, p, tx0, exp_tx);
                end
                n_cmp++;
                if ({flag0, fa0, fd0} !== ((p == 17) ? {1'b1, a, d} : 12'd0)) begin
                    n_err++;
                    $display("FAIL frame_flag f=%0d p=%0d actual=%h required=%h", f, p,
                             {flag0, fa0, fd0}, ((p == 17) ? {1'b1, a, d} : 12'd0));
                end
                n_cmp++;
                if ({rdy0, busy0} !== {(p == 36), (p <= 35)}) begin
                    n_err++;
                    $display("FAIL frame_rdy_busy f=%0d p=%0d actual=%b required=%b", f, p,
                             {rdy0, busy0}, {(p == 36), (p <= 35)});
                end
                // Junk on the inputs while busy must not disturb the frame.
                if (p < 36) begin
                    v0 = 1'($urandom_range(0, 1)); a0 = 7'($urandom); d0 = 4'($urandom);
                end else begin
                    v0 = 1'b0;
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ea[3];
        logic [3:0] ed[3];
        logic exp_tx;
        int p, f;
        n_cmp++;
        if (rdy0 !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready_in actual=%b required=1", rdy0);
        end
        for (int t = 0; t <= 110; t++) begin
            a0 = 7'($urandom); d0 = 4'($urandom); v0 = 1'b1;
            if (t % 37 == 0) begin
                ea[t/37] = a0;
                ed[t/37] = d0;
            end
            @(negedge clk);
            p = t % 37;
            f = t / 37;
            exp_tx = (p >= 1 && p <= 16) ? exp_bit(7, 4, 0, 64'(ea[f]), 64'(ed[f]), p - 1) : 1'b0;
            n_cmp++;
            if (tx0 !== exp_tx) begin
                n_err++;
                $display("FAIL b2b_tx t=%0d actual=%b required=%b", t, tx0, exp_tx);
            end
            n_cmp++;
            if ({flag0, fa0, fd0} !== ((p == 17) ? {1'b1, ea[f], ed[f]} : 12'd0)) begin
                n_err++;
                $display("FAIL b2b_flag t=%0d actual=%h required=%h", t, {flag0, fa0, fd0},
                         ((p == 17) ? {1'b1, ea[f], ed[f]} : 12'd0));
            end
            n_cmp++;
            if (rdy0 !== (p == 36)) begin
                n_err++;
                $display("FAIL b2b_ready t=%0d actual=%b required=%b", t, rdy0, (p == 36));
            end
        end
        v0 = 1'b0;
    endtask

    task automatic test_parity_odd();
        logic exp_tx;
        n_cmp++;
        if (rdy1 !== 1'b1) begin
            n_err++;
            $display("FAIL odd_ready_in actual=%b required=1", rdy1);
        end
        v1 = 1'b1; a1 = 7'h5A; d1 = 4'h3;
        for (int p = 0; p <= 36; p++) begin
            @(negedge clk);
            exp_tx = (p >= 1 && p <= 16) ? exp_bit(7, 4, 1, 64'h5A, 64'h3, p - 1) : 1'b0;
            n_cmp++;
            if (tx1 !== exp_tx) begin
                n_err++;
                $display("FAIL odd_tx p=%0d actual=%b required=%b", p, tx1, exp_tx);
            end
            n_cmp++;
            if ({flag1, fa1, fd1, rdy1} !== {((p == 17) ? {1'b1, 7'h5A, 4'h3} : 12'd0), (p == 36)}) begin
                n_err++;
                $display("FAIL odd_flag_ready p=%0d actual=%h required=%h", p,
                         {flag1, fa1, fd1, rdy1},
                         {((p == 17) ? {1'b1, 7'h5A, 4'h3} : 12'd0), (p == 36)});
            end
            v1 = 1'b0; a1 = 7'($urandom); d1 = 4'($urandom);
        end
    endtask

    task automatic test_wide();
        logic exp_tx;
        n_cmp++;
        if (rdy2 !== 1'b1) begin
            n_err++;
            $display("FAIL wide_ready_in actual=%b required=1", rdy2);
        end
        v2 = 1'b1; a2 = 8'hA5; d2 = 8'h0F;
        for (int p = 0; p <= 83; p++) begin
            @(negedge clk);
            exp_tx = (p >= 1 && p <= 63) ? exp_bit(8, 8, 0, 64'hA5, 64'h0F, (p - 1) / 3) : 1'b0;
            n_cmp++;
            if (tx2 !== exp_tx) begin
                n_err++;
                $display("FAIL wide_tx p=%0d actual=%b required=%b", p, tx2, exp_tx);
            end
            n_cmp++;
            if ({flag2, fa2, fd2, rdy2} !== {((p == 64) ? {1'b1, 8'hA5, 8'h0F} : 17'd0), (p == 83)}) begin
                n_err++;
                $display("FAIL wide_flag_ready p=%0d actual=%h required=%h", p,
                         {flag2, fa2, fd2, rdy2},
                         {((p == 64) ? {1'b1, 8'hA5, 8'h0F} : 17'd0), (p == 83)});
            end
            v2 = 1'b0; a2 = 8'($urandom); d2 = 8'($urandom);
        end
    endtask

    task automatic test_reset_midframe();
        logic [3:0] d;
        logic [6:0] a;
        logic exp_tx;
        logic seen_flag;
        int n;
        d = 4'($urandom);
        v0 = 1'b1; a0 = 7'h7F; d0 = d;
        @(negedge clk);
        v0 = 1'b0;
        repeat (9) @(negedge clk);
        n_cmp++;
        if (tx0 !== exp_bit(7, 4, 0, 64'h7F, 64'(d), 8)) begin
            n_err++;
            $display("FAIL abort_bit8 actual=%b required=1", tx0);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({tx0, busy0, rdy0, flag0} !== 4'b0000) begin
            n_err++;
            $display("FAIL abort_async actual=%b required=0000", {tx0, busy0, rdy0, flag0});
        end
        seen_flag = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen_flag = seen_flag | flag0;
        end
        rst = 1'b0;
        n = 2101;
        for (int i = 1; i <= 2100; i++) begin
            @(negedge clk);
            seen_flag = seen_flag | flag0;
            if (rdy0 === 1'b1) begin
                n = i;
                break;
            end
        end
        n_cmp++;
        if (n != 2000 || seen_flag !== 1'b0) begin
            n_err++;
            $display("FAIL abort_restart actual=%0d/%b required=2000/0", n, seen_flag);
        end
        a = 7'($urandom); d = 4'($urandom);
        v0 = 1'b1; a0 = a; d0 = d;
        for (int p = 0; p <= 17; p++) begin
            @(negedge clk);
            v0 = 1'b0;
            exp_tx = (p >= 1 && p <= 16) ? exp_bit(7, 4, 0, 64'(a), 64'(d), p - 1) : 1'b0;
            n_cmp++;
            if ({tx0, flag0, fa0, fd0} !== {exp_tx, ((p == 17) ? {1'b1, a, d} : 12'd0)}) begin
                n_err++;
                $display("FAIL post_abort_frame p=%0d actual=%h required=%h", p,
                         {tx0, flag0, fa0, fd0}, {exp_tx, ((p == 17) ? {1'b1, a, d} : 12'd0)});
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_default();
        test_back_to_back();
        test_parity_odd();
        test_wide();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
